wb_regfile_unit: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value and destination, then commits it to a 32x64 integer register file and a 32x64 FP register file.
- Serves the ID stage through four combinational read ports with write-before-read bypass.
- Keeps a retired-write counter for debug/perf.

---
 rtl/wb_pkg.sv | 17 +
 rtl/regfile_2r1w.sv | 49 ++++
 rtl/wb_regfile_unit.sv | 79 +++++++
 tb/tb_wb_regfile_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback stage and its register files.
package wb_pkg;

  localparam int DATA_W   = 64;
  localparam int NREGS    = 32;
  localparam int REG_AW   = 5;
  localparam int LINK_REG = 31;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    WB_TGT_INT = 1'b0,
    WB_TGT_FP  = 1'b1
  } wb_target_e;

endpackage

// File: rtl/regfile_2r1w.sv
// NREGS x DATA_W register file: one write port, two combinational read ports
// with same-cycle write-to-read bypass; optional hardwired-zero entry 0.
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int NREGS   = wb_pkg::NREGS,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  reg_addr_t         waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_addr_t         raddr_a,
  input  reg_addr_t         raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // NOTE: the whole array is cleared on reset because software-visible
  // registers must read zero afterwards; this forces flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && !(ZERO_R0 && waddr == '0)) begin
      mem[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_mux(input reg_addr_t         raddr,
                                                 input logic [DATA_W-1:0] entry);
    logic [DATA_W-1:0] val;
    val = entry;
    if (we && waddr == raddr) val = wdata;
    if (ZERO_R0 && raddr == '0) val = '0;
    return val;
  endfunction

  // NOTE: every comb output gets a value on all paths (inside read_mux),
  // so no latch is inferred.
  always_comb begin
    rdata_a = read_mux(raddr_a, mem[raddr_a]);
    rdata_b = read_mux(raddr_b, mem[raddr_b]);
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback stage: selects value/destination from MEM/WB, commits to the
// integer and FP register files, and counts retired writes.
module wb_regfile_unit
  import wb_pkg::*;
#(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int NREGS    = wb_pkg::NREGS,
  parameter int LINK_REG = wb_pkg::LINK_REG,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] MEM_WB_MemData,
  input  logic [DATA_W-1:0] MEM_WB_ALUData,
  input  logic [4:0]        MEM_WB_DstReg,
  input  logic [4:0]        MEM_WB_FP_DstReg,
  input  logic              MEM_WB_MemtoReg,
  input  logic              MEM_WB_RegWrite,
  input  logic              MEM_WB_R_memtoReg,
  input  logic              MEM_WB_JmpandLink,
  input  logic [4:0]        ID_RsAddr,
  input  logic [4:0]        ID_RtAddr,
  input  logic [4:0]        ID_FsAddr,
  input  logic [4:0]        ID_FtAddr,
  output logic [DATA_W-1:0] ID_RsData,
  output logic [DATA_W-1:0] ID_RtData,
  output logic [DATA_W-1:0] ID_FsData,
  output logic [DATA_W-1:0] ID_FtData,
  output logic [DATA_W-1:0] WB_Data,
  output logic              WB_IntWrEn,
  output logic              WB_FpWrEn,
  output logic [CNT_W-1:0]  WB_RetireCnt
);

  wb_target_e tgt;
  reg_addr_t  int_addr;

  // Jump-and-link wins over both the load select and the FP target.
  always_comb begin
    WB_Data  = (MEM_WB_MemtoReg && !MEM_WB_JmpandLink) ? MEM_WB_MemData : MEM_WB_ALUData;
    tgt      = (MEM_WB_R_memtoReg && !MEM_WB_JmpandLink) ? WB_TGT_FP : WB_TGT_INT;
    int_addr = MEM_WB_JmpandLink ? reg_addr_t'(LINK_REG) : MEM_WB_DstReg;
  end

  assign WB_IntWrEn = rst_n && MEM_WB_RegWrite && (tgt == WB_TGT_INT) && (int_addr != '0);
  assign WB_FpWrEn  = rst_n && MEM_WB_RegWrite && (tgt == WB_TGT_FP);

  // NOTE: sequential state uses non-blocking assignment so all flops update
  // from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)                      WB_RetireCnt <= '0;
    else if (WB_IntWrEn || WB_FpWrEn) WB_RetireCnt <= WB_RetireCnt + CNT_W'(1);
  end

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS), .ZERO_R0(1'b1)) u_int_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (WB_IntWrEn),
    .waddr   (int_addr),
    .wdata   (WB_Data),
    .raddr_a (ID_RsAddr),
    .raddr_b (ID_RtAddr),
    .rdata_a (ID_RsData),
    .rdata_b (ID_RtData)
  );

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS), .ZERO_R0(1'b0)) u_fp_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (WB_FpWrEn),
    .waddr   (MEM_WB_FP_DstReg),
    .wdata   (WB_Data),
    .raddr_a (ID_FsAddr),
    .raddr_b (ID_FtAddr),
    .rdata_a (ID_FsData),
    .rdata_b (ID_FtData)
  );

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit: default instance plus a 4-bit counter
// instance sharing the same stimulus.
module tb_wb_regfile_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mem_data, alu_data;
  logic [4:0]  dst_reg, fp_dst_reg;
  logic        memto_reg, reg_write, r_memto_reg, jmp_link;
  logic [4:0]  rs_addr, rt_addr, fs_addr, ft_addr;

  logic [63:0] rs_data, rt_data, fs_data, ft_data, wb_data;
  logic        int_we, fp_we;
  logic [31:0] retire_cnt;

  logic [63:0] w_rs_data, w_rt_data, w_fs_data, w_ft_data, w_wb_data;
  logic        w_int_we, w_fp_we;
  logic [3:0]  w_retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_regfile_unit dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_WB_MemData(mem_data), .MEM_WB_ALUData(alu_data),
    .MEM_WB_DstReg(dst_reg), .MEM_WB_FP_DstReg(fp_dst_reg),
    .MEM_WB_MemtoReg(memto_reg), .MEM_WB_RegWrite(reg_write),
    .MEM_WB_R_memtoReg(r_memto_reg), .MEM_WB_JmpandLink(jmp_link),
    .ID_RsAddr(rs_addr), .ID_RtAddr(rt_addr), .ID_FsAddr(fs_addr), .ID_FtAddr(ft_addr),
    .ID_RsData(rs_data), .ID_RtData(rt_data), .ID_FsData(fs_data), .ID_FtData(ft_data),
    .WB_Data(wb_data), .WB_IntWrEn(int_we), .WB_FpWrEn(fp_we), .WB_RetireCnt(retire_cnt)
  );

  wb_regfile_unit #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .MEM_WB_MemData(mem_data), .MEM_WB_ALUData(alu_data),
    .MEM_WB_DstReg(dst_reg), .MEM_WB_FP_DstReg(fp_dst_reg),
    .MEM_WB_MemtoReg(memto_reg), .MEM_WB_RegWrite(reg_write),
    .MEM_WB_R_memtoReg(r_memto_reg), .MEM_WB_JmpandLink(jmp_link),
    .ID_RsAddr(rs_addr), .ID_RtAddr(rt_addr), .ID_FsAddr(fs_addr), .ID_FtAddr(ft_addr),
    .ID_RsData(w_rs_data), .ID_RtData(w_rt_data), .ID_FsData(w_fs_data), .ID_FtData(w_ft_data),
    .WB_Data(w_wb_data), .WB_IntWrEn(w_int_we), .WB_FpWrEn(w_fp_we), .WB_RetireCnt(w_retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 unit after the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; reg_write = 1'b1; jmp_link = 1'b0; memto_reg = 1'b0; r_memto_reg = 1'b0;
    mem_data = 64'h77; alu_data = 64'h55; dst_reg = 5'd5; fp_dst_reg = 5'd5;
    rs_addr = 5'd5; rt_addr = 5'd6; fs_addr = 5'd5; ft_addr = 5'd0;

    // Reset with a write pending: nothing commits, nothing bypasses.
    step(); step();
    check("rst_int_we", int_we, 0);
    check("rst_fp_we", fp_we, 0);
    check("rst_rs_nobypass", rs_data, 0);
    rst_n = 1'b1; reg_write = 1'b0;
    #1;
    check("rst_rs", rs_data, 0);
    check("rst_fs", fs_data, 0);
    check("rst_ft", ft_data, 0);
    check("rst_cnt", retire_cnt, 0);

    // Integer ALU write to r5, bypassed same cycle.
    reg_write = 1'b1; dst_reg = 5'd5; alu_data = 64'h1234; memto_reg = 1'b0;
    #1;
    check("alu_wbdata", wb_data, 64'h1234);
    check("alu_int_we", int_we, 1);
    check("alu_rs_bypass", rs_data, 64'h1234);
    step();
    // Load write to r6.
    dst_reg = 5'd6; mem_data = 64'hDEADBEEF; memto_reg = 1'b1;
    #1;
    check("ld_rt_bypass", rt_data, 64'hDEADBEEF);
    check("ld_rs_array", rs_data, 64'h1234);
    step();
    reg_write = 1'b0;
    #1;
    check("ld_rt_array", rt_data, 64'hDEADBEEF);
    check("ld_cnt", retire_cnt, 2);

    // FP write to f0.
    reg_write = 1'b1; r_memto_reg = 1'b1; fp_dst_reg = 5'd0; dst_reg = 5'd0;
    mem_data = 64'h3FF0000000000000; memto_reg = 1'b1; fs_addr = 5'd0; rs_addr = 5'd0;
    #1;
    check("fp_fp_we", fp_we, 1);
    check("fp_int_we", int_we, 0);
    check("fp_fs_bypass", fs_data, 64'h3FF0000000000000);
    step();
    reg_write = 1'b0;
    #1;
    check("fp_fs_array", fs_data, 64'h3FF0000000000000);
    check("fp_ft_alias", ft_data, 64'h3FF0000000000000);
    check("fp_r0", rs_data, 0);
    check("fp_cnt", retire_cnt, 3);

    // Write to integer r0 is dropped.
    reg_write = 1'b1; r_memto_reg = 1'b0; dst_reg = 5'd0; alu_data = 64'hFF; memto_reg = 1'b0;
    #1;
    check("r0_int_we", int_we, 0);
    check("r0_rs_bypass", rs_data, 0);
    step();
    reg_write = 1'b0;
    #1;
    check("r0_rs", rs_data, 0);
    check("r0_cnt", retire_cnt, 3);

    // Jump-and-link overrides MemtoReg, DstReg and the FP target.
    reg_write = 1'b1; jmp_link = 1'b1; alu_data = 64'h400010; mem_data = 64'h999;
    memto_reg = 1'b1; dst_reg = 5'd3; r_memto_reg = 1'b1; fp_dst_reg = 5'd2;
    rs_addr = 5'd31; rt_addr = 5'd3; fs_addr = 5'd2;
    #1;
    check("jal_wbdata", wb_data, 64'h400010);
    check("jal_int_we", int_we, 1);
    check("jal_fp_we", fp_we, 0);
    check("jal_rs_bypass", rs_data, 64'h400010);
    step();
    reg_write = 1'b0; jmp_link = 1'b0;
    #1;
    check("jal_r31", rs_data, 64'h400010);
    check("jal_r3", rt_data, 0);
    check("jal_f2", fs_data, 0);
    check("jal_cnt", retire_cnt, 4);

    // RegWrite low: no strobes, no change.
    dst_reg = 5'd5; alu_data = 64'hCAFE; memto_reg = 1'b0; r_memto_reg = 1'b0;
    rs_addr = 5'd5; fs_addr = 5'd0;
    #1;
    check("nowr_int_we", int_we, 0);
    check("nowr_rs_bypass", rs_data, 64'h1234);
    r_memto_reg = 1'b1;
    #1;
    check("nowr_fp_we", fp_we, 0);
    step();
    r_memto_reg = 1'b0;
    #1;
    check("nowr_rs", rs_data, 64'h1234);
    check("nowr_fs", fs_data, 64'h3FF0000000000000);
    check("nowr_cnt", retire_cnt, 4);

    // Reset arriving alongside an in-flight write.
    reg_write = 1'b1; dst_reg = 5'd7; alu_data = 64'hAA;
    step();
    dst_reg = 5'd8; alu_data = 64'hBB; rst_n = 1'b0;
    #1;
    check("mrst_int_we", int_we, 0);
    step();
    rst_n = 1'b1; reg_write = 1'b0; rs_addr = 5'd7; rt_addr = 5'd8;
    #1;
    check("mrst_r7", rs_data, 0);
    check("mrst_r8", rt_data, 0);
    check("mrst_f0", fs_data, 0);
    check("mrst_cnt", retire_cnt, 0);
    check("mrst_cnt_w", w_retire_cnt, 0);

    // 17 writes: the 4-bit counter wraps to 1.
    reg_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dst_reg  = 5'(i % 31 + 1);
      alu_data = 64'(i);
      step();
    end
    reg_write = 1'b0; rs_addr = 5'd17;
    #1;
    check("wrap_cnt_w", w_retire_cnt, 1);
    check("wrap_cnt", retire_cnt, 17);
    check("wrap_r17", rs_data, 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
